// File: rtl/graph_eval_scheduler.sv
// -----------------------------------------------------------------------------
// graph_eval_scheduler
//
// Steps one shared function evaluator across every display column for both
// graph slots and writes each result into the plotter's column sample buffer.
// The plotter then reads stored samples and does no per-pixel arithmetic.
//
// A sweep visits (col 0, slot 0), (col 0, slot 1), (col 1, slot 0), ... up to
// (NUM_COLS-1, slot 1). Slots whose latched type is 2'b11 are skipped in a
// single cycle. Every enabled slot issues one req/ack transaction. If the
// evaluator does not answer within TIMEOUT cycles, a marker sample is written
// and a sticky flag is raised.
//
// Ports
//   clk, reset         system clock, asynchronous active-high reset
//   start              single-cycle pulse: begin or restart a sweep
//   graph1_type        slot-0 function type (2'b11 = unused), latched on start
//   graph2_type        slot-1 function type (2'b11 = unused), latched on start
//   eval_req           request to the shared evaluator
//   eval_slot          slot being evaluated (0 = graph1, 1 = graph2)
//   eval_x             signed x = col - NUM_COLS/2
//   eval_ack           evaluator result valid this cycle
//   eval_result        signed evaluator result
//   wr_en              sample buffer write strobe
//   wr_slot, wr_col    sample buffer address
//   wr_data            sample value
//   busy               sweep in progress
//   done               one-cycle pulse at sweep completion
//   timeout_flag       sticky: a request timed out during this sweep
// -----------------------------------------------------------------------------
module graph_eval_scheduler #(
  parameter int NUM_COLS = 96,
  parameter int COL_BITS = 7,
  parameter int Y_BITS   = 16,
  parameter int TIMEOUT  = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               graph1_type,
  input  logic [1:0]               graph2_type,
  output logic                     eval_req,
  output logic                     eval_slot,
  output logic signed [7:0]        eval_x,
  input  logic                     eval_ack,
  input  logic signed [Y_BITS-1:0] eval_result,
  output logic                     wr_en,
  output logic                     wr_slot,
  output logic [COL_BITS-1:0]      wr_col,
  output logic signed [Y_BITS-1:0] wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_flag
);

  localparam int                       CNT_W          = $clog2(TIMEOUT + 1);
  localparam logic [COL_BITS-1:0]      LAST_COL       = COL_BITS'(NUM_COLS - 1);
  localparam logic [CNT_W-1:0]         CNT_MAX        = CNT_W'(TIMEOUT - 1);
  localparam logic signed [7:0]        X_OFFSET       = 8'(NUM_COLS / 2);
  localparam logic signed [Y_BITS-1:0] TIMEOUT_SAMPLE = {1'b1, {(Y_BITS-1){1'b0}}};
  localparam logic [1:0]               TYPE_UNUSED    = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_REQ   = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t                     r_state;
  state_t                     w_next_state;
  logic [COL_BITS-1:0]        r_col;
  logic                       r_slot;
  logic [1:0]                 r_type1;
  logic [1:0]                 r_type2;
  logic [CNT_W-1:0]           r_cnt;
  logic signed [Y_BITS-1:0]   r_wr_data;
  logic                       r_timeout;
  logic                       r_done;

  logic                       w_slot_unused;
  logic                       w_last;
  logic                       w_advance;
  logic                       w_capture;
  logic                       w_expire;
  logic                       w_cnt_inc;
  logic                       w_done_set;
  logic signed [7:0]          w_x;

  assign w_slot_unused = ((r_slot ? r_type2 : r_type1) == TYPE_UNUSED);
  // The final position of a sweep is the last column, second slot.
  assign w_last        = (r_col == LAST_COL) && r_slot;
  assign w_done_set    = w_advance && w_last;
  assign w_x           = $signed(8'(r_col)) - X_OFFSET;

  always_comb begin
    w_next_state = r_state;
    w_advance    = 1'b0;
    w_capture    = 1'b0;
    w_expire     = 1'b0;
    w_cnt_inc    = 1'b0;

    case (r_state)
      S_IDLE: w_next_state = S_IDLE;
      S_CHECK: begin
        if (w_slot_unused) begin
          w_advance    = 1'b1;
          w_next_state = w_last ? S_IDLE : S_CHECK;
        end else begin
          w_next_state = S_REQ;
        end
      end
      S_REQ: begin
        if (eval_ack) begin
          w_capture    = 1'b1;
          w_next_state = S_WRITE;
        end else if (r_cnt == CNT_MAX) begin
          w_expire     = 1'b1;
          w_next_state = S_WRITE;
        end else begin
          w_cnt_inc    = 1'b1;
        end
      end
      S_WRITE: begin
        w_advance    = 1'b1;
        w_next_state = w_last ? S_IDLE : S_CHECK;
      end
      default: w_next_state = S_IDLE;
    endcase

    // start overrides everything: an in-flight request is abandoned (its ack,
    // if any, is ignored) and the sweep restarts through CHECK, so eval_req is
    // low for at least one cycle before the next request.
    if (start) begin
      w_next_state = S_CHECK;
      w_advance    = 1'b0;
      w_capture    = 1'b0;
      w_expire     = 1'b0;
      w_cnt_inc    = 1'b0;
    end

    // Address outputs are qualified by their strobes so that they read zero
    // whenever no transaction is in progress.
    eval_req     = (r_state == S_REQ);
    eval_slot    = eval_req && r_slot;
    eval_x       = eval_req ? w_x : 8'sd0;
    wr_en        = (r_state == S_WRITE);
    wr_slot      = wr_en && r_slot;
    wr_col       = wr_en ? r_col : '0;
    wr_data      = r_wr_data;
    busy         = (r_state != S_IDLE);
    done         = r_done;
    timeout_flag = r_timeout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_col     <= '0;
      r_slot    <= 1'b0;
      r_type1   <= 2'b00;
      r_type2   <= 2'b00;
      r_cnt     <= '0;
      r_wr_data <= '0;
      r_timeout <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_done_set;
      if (start) begin
        r_type1   <= graph1_type;
        r_type2   <= graph2_type;
        r_col     <= '0;
        r_slot    <= 1'b0;
        r_timeout <= 1'b0;
        r_cnt     <= '0;
      end else begin
        // The counter holds the number of unanswered REQ cycles so far and
        // is zero whenever a request is not pending.
        r_cnt <= w_cnt_inc ? r_cnt + CNT_W'(1) : '0;
        if (w_capture) begin
          r_wr_data <= eval_result;
        end
        if (w_expire) begin
          r_wr_data <= TIMEOUT_SAMPLE;
          r_timeout <= 1'b1;
        end
        if (w_advance) begin
          if (!r_slot) begin
            r_slot <= 1'b1;
          end else begin
            r_slot <= 1'b0;
            r_col  <= w_last ? '0 : r_col + COL_BITS'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_graph_eval_scheduler.sv
`timescale 1ns/1ps
module tb_graph_eval_scheduler;
  localparam int NUM_COLS = 96;
  localparam int COL_BITS = 7;
  localparam int Y_BITS   = 16;
  localparam int TIMEOUT  = 64;
  localparam int NENT     = 2 * NUM_COLS;
  localparam int BUDGET   = 5000;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     start;
  logic [1:0]               graph1_type;
  logic [1:0]               graph2_type;
  logic                     eval_req;
  logic                     eval_slot;
  logic signed [7:0]        eval_x;
  logic                     eval_ack;
  logic signed [Y_BITS-1:0] eval_result;
  logic                     wr_en;
  logic                     wr_slot;
  logic [COL_BITS-1:0]      wr_col;
  logic signed [Y_BITS-1:0] wr_data;
  logic                     busy;
  logic                     done;
  logic                     timeout_flag;

  always #5 clk = ~clk;

  graph_eval_scheduler #(
    .NUM_COLS(NUM_COLS), .COL_BITS(COL_BITS), .Y_BITS(Y_BITS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .graph1_type(graph1_type), .graph2_type(graph2_type),
    .eval_req(eval_req), .eval_slot(eval_slot), .eval_x(eval_x),
    .eval_ack(eval_ack), .eval_result(eval_result),
    .wr_en(wr_en), .wr_slot(wr_slot), .wr_col(wr_col), .wr_data(wr_data),
    .busy(busy), .done(done), .timeout_flag(timeout_flag)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- evaluator stand-in ----------------
  int          lat_tab [NENT];
  logic [6:0]  salt      = 7'd0;
  bit          noise_en  = 1'b0;
  int          noack_col = -1;
  logic        force_ack = 1'b0;
  logic        resp_ack  = 1'b0;
  logic [15:0] resp_result = 16'h0;
  int          resp_age  = 0;
  logic        prev_req_r = 1'b0;

  assign eval_ack    = resp_ack | force_ack;
  assign eval_result = resp_result;

  function automatic bit want_ack(input logic signed [7:0] x, input logic s, input int age);
    int col;
    col = int'(x) + NUM_COLS / 2;
    if (col < 0 || col >= NUM_COLS) return 1'b1;
    if (!s && col == noack_col) return 1'b0;
    return age == lat_tab[2 * col + int'(s)];
  endfunction

  always @(negedge clk) begin
    if (eval_req) begin
      resp_age    <= prev_req_r ? resp_age + 1 : 0;
      resp_ack    <= want_ack(eval_x, eval_slot, prev_req_r ? resp_age + 1 : 0);
      resp_result <= {eval_x, salt, eval_slot};
    end else begin
      resp_age    <= 0;
      resp_ack    <= noise_en && ($urandom_range(0, 3) == 0);
      resp_result <= 16'($urandom);
    end
    prev_req_r <= eval_req;
  end

  // ---------------- monitor ----------------
  typedef struct packed {
    logic                slot;
    logic [COL_BITS-1:0] col;
    logic [15:0]         data;
  } wr_t;

  wr_t         wq [$];
  logic [7:0]  rq [$];
  int busy_cnt = 0, done_cnt = 0, done_busy = 0, req_s1 = 0, noack_cyc = 0;
  logic mon_prev_req = 1'b0;

  always @(negedge clk) begin
    if (wr_en) wq.push_back({wr_slot, wr_col, wr_data});
    if (busy) busy_cnt <= busy_cnt + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      if (busy) done_busy <= done_busy + 1;
    end
    if (eval_req) begin
      if (eval_slot) req_s1 <= req_s1 + 1;
      if (!eval_slot && int'(eval_x) + NUM_COLS / 2 == noack_col) noack_cyc <= noack_cyc + 1;
      if (!mon_prev_req) rq.push_back(eval_x);
    end
    mon_prev_req <= eval_req;
  end

  int b_wq, b_rq, b_busy, b_done, b_done_busy, b_s1, b_noack;

  task automatic mark();
    b_wq = wq.size(); b_rq = rq.size(); b_busy = busy_cnt; b_done = done_cnt;
    b_done_busy = done_busy; b_s1 = req_s1; b_noack = noack_cyc;
  endtask

  // ---------------- reference model ----------------
  wr_t exp_q [$];
  int  exp_busy;

  // Walk the sweep in visiting order and list the writes and cycle cost.
  task automatic build_model(input logic [1:0] t1, input logic [1:0] t2);
    logic [1:0] t;
    exp_q.delete();
    exp_busy = 0;
    for (int c = 0; c < NUM_COLS; c++) begin
      for (int s = 0; s < 2; s++) begin
        t = (s == 1) ? t2 : t1;
        if (t == 2'b11) begin
          exp_busy += 1;
        end else if (s == 0 && c == noack_col) begin
          exp_busy += 2 + TIMEOUT;
          exp_q.push_back({1'b0, 7'(c), 16'h8000});
        end else begin
          exp_busy += 3 + lat_tab[2 * c + s];
          exp_q.push_back({1'(s), 7'(c), 8'(c - NUM_COLS / 2), salt, 1'(s)});
        end
      end
    end
  endtask

  task automatic set_lat(input int lo, input int hi);
    for (int i = 0; i < NENT; i++) lat_tab[i] = $urandom_range(lo, hi);
  endtask

  function automatic int n_writes();
    return wq.size() - b_wq;
  endfunction

  // Index of first write differing from the model (or first missing/extra), -1 if identical.
  function automatic int first_bad();
    int n = (n_writes() < exp_q.size()) ? n_writes() : exp_q.size();
    for (int i = 0; i < n; i++) if (wq[b_wq + i] !== exp_q[i]) return i;
    if (n_writes() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic wr_t got_at(input int i);
    return (i >= 0 && i < n_writes()) ? wq[b_wq + i] : '1;
  endfunction

  function automatic wr_t exp_at(input int i);
    return (i >= 0 && i < exp_q.size()) ? exp_q[i] : '1;
  endfunction

  task automatic start_sweep(input logic [1:0] t1, input logic [1:0] t2);
    @(negedge clk);
    graph1_type = t1; graph2_type = t2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mark();
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; graph1_type = 2'b00; graph2_type = 2'b00;
    set_lat(0, 0);
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if ({eval_req, eval_slot, eval_x, wr_en, wr_slot, wr_col, wr_data, busy, done, timeout_flag} !== '0)
      $display("FAIL reset_outputs: got %h, expected 0",
               {eval_req, eval_slot, eval_x, wr_en, wr_slot, wr_col, wr_data, busy, done, timeout_flag});
    else n_pass++;
    @(negedge clk); reset = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if ({busy, eval_req, wr_en, done} !== 4'b0) $display("FAIL idle_after_reset: got %b, expected 0000", {busy, eval_req, wr_en, done});
    else n_pass++;
  endtask

  task automatic test_full_l0();
    logic [1:0] t1, t2;
    bit ok;
    int fb;
    t1 = 2'($urandom_range(0, 2)); t2 = 2'($urandom_range(0, 2));
    salt = 7'($urandom); noise_en = 1'b1; set_lat(0, 0);
    build_model(t1, t2);
    start_sweep(t1, t2);
    wait_done(ok);
    n_checks++; if (!ok) $display("FAIL full_done_seen: got none, expected done within %0d", BUDGET); else n_pass++;
    n_checks++; if (n_writes() != 192) $display("FAIL full_writes: got %0d, expected 192", n_writes()); else n_pass++;
    fb = first_bad();
    n_checks++; if (fb != -1) $display("FAIL full_order: index %0d got %h, expected %h", fb, got_at(fb), exp_at(fb)); else n_pass++;
    n_checks++; if (busy_cnt - b_busy != 576) $display("FAIL full_busy: got %0d, expected 576", busy_cnt - b_busy); else n_pass++;
    n_checks++; if (done_cnt - b_done != 1) $display("FAIL full_done_count: got %0d, expected 1", done_cnt - b_done); else n_pass++;
    n_checks++; if (done_busy != b_done_busy) $display("FAIL full_done_busy: got %0d, expected 0", done_busy - b_done_busy); else n_pass++;
    n_checks++; if (timeout_flag !== 1'b0) $display("FAIL full_timeout_flag: got %b, expected 0", timeout_flag); else n_pass++;
    n_checks++;
    if (rq.size() <= b_rq || rq[b_rq] !== 8'hD0) $display("FAIL full_first_x: got %h, expected d0", (rq.size() > b_rq) ? rq[b_rq] : 8'hxx);
    else n_pass++;
    n_checks++; if (rq.size() - b_rq != 192) $display("FAIL full_requests: got %0d, expected 192", rq.size() - b_rq); else n_pass++;
  endtask

  task automatic test_slot2_unused();
    logic [1:0] t1;
    bit ok;
    int fb;
    t1 = 2'($urandom_range(0, 2));
    salt = 7'($urandom); noise_en = 1'b1; set_lat(3, 3);
    build_model(t1, 2'b11);
    start_sweep(t1, 2'b11);
    repeat (20) @(negedge clk);
    graph1_type = 2'b11; graph2_type = 2'b00;
    wait_done(ok);
    n_checks++; if (!ok) $display("FAIL s2_done_seen: got none, expected done within %0d", BUDGET); else n_pass++;
    n_checks++; if (n_writes() != 96) $display("FAIL s2_writes: got %0d, expected 96", n_writes()); else n_pass++;
    fb = first_bad();
    n_checks++; if (fb != -1) $display("FAIL s2_order: index %0d got %h, expected %h", fb, got_at(fb), exp_at(fb)); else n_pass++;
    n_checks++; if (req_s1 != b_s1) $display("FAIL s2_slot1_requests: got %0d, expected 0", req_s1 - b_s1); else n_pass++;
    n_checks++; if (busy_cnt - b_busy != 672) $display("FAIL s2_busy: got %0d, expected 672", busy_cnt - b_busy); else n_pass++;
    n_checks++; if (done_cnt - b_done != 1) $display("FAIL s2_done_count: got %0d, expected 1", done_cnt - b_done); else n_pass++;
  endtask

  task automatic test_timeout();
    logic [1:0] t1, t2;
    bit ok;
    int fb;
    t1 = 2'($urandom_range(0, 2)); t2 = 2'($urandom_range(0, 2));
    salt = 7'($urandom); noise_en = 1'b1; set_lat(0, 3); noack_col = 5;
    build_model(t1, t2);
    start_sweep(t1, t2);
    wait_done(ok);
    n_checks++; if (!ok) $display("FAIL to_done_seen: got none, expected done within %0d", BUDGET); else n_pass++;
    n_checks++; if (noack_cyc - b_noack != TIMEOUT) $display("FAIL to_req_cycles: got %0d, expected %0d", noack_cyc - b_noack, TIMEOUT); else n_pass++;
    n_checks++; if (n_writes() != 192) $display("FAIL to_writes: got %0d, expected 192", n_writes()); else n_pass++;
    fb = first_bad();
    n_checks++; if (fb != -1) $display("FAIL to_order: index %0d got %h, expected %h", fb, got_at(fb), exp_at(fb)); else n_pass++;
    n_checks++; if (busy_cnt - b_busy != exp_busy) $display("FAIL to_busy: got %0d, expected %0d", busy_cnt - b_busy, exp_busy); else n_pass++;
    n_checks++; if (done_cnt - b_done != 1) $display("FAIL to_done_count: got %0d, expected 1", done_cnt - b_done); else n_pass++;
    repeat (5) @(posedge clk); #1;
    n_checks++; if (timeout_flag !== 1'b1) $display("FAIL to_flag_sticky: got %b, expected 1", timeout_flag); else n_pass++;
    noack_col = -1;
  endtask

  task automatic test_abort();
    logic [1:0] t1, t2;
    bit ok, found;
    int fb;
    wr_t exp_prev;
    t1 = 2'($urandom_range(0, 2)); t2 = 2'($urandom_range(0, 2));
    salt = 7'($urandom); noise_en = 1'b1; set_lat(0, 2);
    build_model(t1, t2);
    exp_prev = exp_q[2 * 39 + 1];
    start_sweep(t1, t2);
    n_checks++; if (timeout_flag !== 1'b0) $display("FAIL ab_flag_cleared: got %b, expected 0", timeout_flag); else n_pass++;
    found = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (eval_req && !eval_slot && eval_x == -8'sd8) begin found = 1'b1; break; end
    end
    n_checks++; if (!found) $display("FAIL ab_reach_col40: got none, expected request at col 40"); else n_pass++;
    n_checks++; if (done_cnt != b_done) $display("FAIL ab_early_done: got %0d, expected 0", done_cnt - b_done); else n_pass++;
    n_checks++;
    if (wq.size() == 0 || wq[$] !== exp_prev) $display("FAIL ab_last_before: got %h, expected %h", (wq.size() > 0) ? wq[$] : '1, exp_prev);
    else n_pass++;
    // Restart with a stale ack coinciding with the start pulse.
    t1 = 2'($urandom_range(0, 2)); t2 = 2'($urandom_range(0, 2));
    graph1_type = t1; graph2_type = t2; start = 1'b1; force_ack = 1'b1;
    build_model(t1, t2);
    @(posedge clk); #1;
    start = 1'b0; force_ack = 1'b0;
    mark();
    n_checks++; if ({eval_req, busy, wr_en} !== 3'b010) $display("FAIL ab_req_gap: got %b, expected 010", {eval_req, busy, wr_en}); else n_pass++;
    wait_done(ok);
    n_checks++; if (!ok) $display("FAIL ab_done_seen: got none, expected done within %0d", BUDGET); else n_pass++;
    fb = first_bad();
    n_checks++; if (fb != -1) $display("FAIL ab_order: index %0d got %h, expected %h", fb, got_at(fb), exp_at(fb)); else n_pass++;
    n_checks++; if (busy_cnt - b_busy != exp_busy) $display("FAIL ab_busy: got %0d, expected %0d", busy_cnt - b_busy, exp_busy); else n_pass++;
    n_checks++; if (done_cnt - b_done != 1) $display("FAIL ab_done_count: got %0d, expected 1", done_cnt - b_done); else n_pass++;
  endtask

  task automatic test_both_unused();
    bit ok;
    noise_en = 1'b1;
    start_sweep(2'b11, 2'b11);
    wait_done(ok);
    n_checks++; if (!ok) $display("FAIL bu_done_seen: got none, expected done within %0d", BUDGET); else n_pass++;
    n_checks++; if (n_writes() != 0) $display("FAIL bu_writes: got %0d, expected 0", n_writes()); else n_pass++;
    n_checks++; if (rq.size() != b_rq) $display("FAIL bu_requests: got %0d, expected 0", rq.size() - b_rq); else n_pass++;
    n_checks++; if (busy_cnt - b_busy != 192) $display("FAIL bu_busy: got %0d, expected 192", busy_cnt - b_busy); else n_pass++;
    n_checks++; if (done_cnt - b_done != 1) $display("FAIL bu_done_count: got %0d, expected 1", done_cnt - b_done); else n_pass++;
    n_checks++; if (done_busy != b_done_busy) $display("FAIL bu_done_busy: got %0d, expected 0", done_busy - b_done_busy); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [1:0] t1, t2;
    bit ok;
    int fb;
    t1 = 2'($urandom_range(0, 2)); t2 = 2'($urandom_range(0, 2));
    salt = 7'($urandom); noise_en = 1'b1; set_lat(0, 3);
    start_sweep(t1, t2);
    repeat (150) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    n_checks++;
    if ({eval_req, eval_slot, eval_x, wr_en, wr_slot, wr_col, wr_data, busy, done, timeout_flag} !== '0)
      $display("FAIL rm_async_outputs: got %h, expected 0",
               {eval_req, eval_slot, eval_x, wr_en, wr_slot, wr_col, wr_data, busy, done, timeout_flag});
    else n_pass++;
    mark();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk); #1;
    n_checks++; if (done_cnt != b_done || busy !== 1'b0) $display("FAIL rm_no_done: got %0d/%b, expected 0/0", done_cnt - b_done, busy); else n_pass++;
    build_model(t1, t2);
    start_sweep(t1, t2);
    wait_done(ok);
    n_checks++; if (!ok) $display("FAIL rm_done_seen: got none, expected done within %0d", BUDGET); else n_pass++;
    fb = first_bad();
    n_checks++; if (fb != -1) $display("FAIL rm_order: index %0d got %h, expected %h", fb, got_at(fb), exp_at(fb)); else n_pass++;
    n_checks++; if (busy_cnt - b_busy != exp_busy) $display("FAIL rm_busy: got %0d, expected %0d", busy_cnt - b_busy, exp_busy); else n_pass++;
    n_checks++; if (done_cnt - b_done != 1) $display("FAIL rm_done_count: got %0d, expected 1", done_cnt - b_done); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_l0();
    test_slot2_unused();
    test_timeout();
    test_abort();
    test_both_unused();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
